// File: rtl/pipe_collide_score_pkg.sv
// Shared game constants for the pipe/bird blocks.
//   - Default playfield geometry, in pixels.
//   - Encoding of the one-hot round state.
package pipe_collide_score_pkg;

   localparam int unsigned DEF_BIRD_X    = 200;
   localparam int unsigned DEF_BIRD_SIZE = 20;
   localparam int unsigned DEF_PIPE_W    = 50;
   localparam int unsigned DEF_GAP_H     = 150;
   localparam int unsigned DEF_FLOOR_Y   = 460;
   localparam int unsigned DEF_SCREEN_W  = 640;

   // One-hot round state. Any other pattern is illegal and recovers to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_PLAY = 3'b010,
      ST_LOST = 3'b100
   } state_t;

endpackage

// File: rtl/pipe_collide_score_pipe_checker.sv
// pipe_checker: collision and pass detection for one pipe.
//   Clk, Reset   : clock, synchronous active-high reset
//   X, Y         : pipe left edge / gap top edge
//   BirdPosY     : bird top edge
//   hit          : combinational, bird overlaps the pipe body
//   pass         : combinational, armed pipe is fully left of the bird
// The Armed flag lives here. It clears on a pass and re-sets once the pipe
// is back to the right of the bird, so each pipe scores once per sweep.
module pipe_checker
   import pipe_collide_score_pkg::*;
#(
   parameter int unsigned BIRD_X    = DEF_BIRD_X,
   parameter int unsigned BIRD_SIZE = DEF_BIRD_SIZE,
   parameter int unsigned PIPE_W    = DEF_PIPE_W,
   parameter int unsigned GAP_H     = DEF_GAP_H,
   parameter int unsigned SCREEN_W  = DEF_SCREEN_W
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [9:0] X,
   input  logic [9:0] Y,
   input  logic [9:0] BirdPosY,
   output logic       hit,
   output logic       pass
);

   localparam logic [10:0] BIRD_L = 11'(BIRD_X);
   localparam logic [10:0] BIRD_R = 11'(BIRD_X + BIRD_SIZE);
   localparam logic [10:0] SCR_W  = 11'(SCREEN_W);

   logic        armed;
   logic [10:0] x11, pipe_r, gap_bot, bird_bot;
   logic        on_screen, x_overlap, y_outside;

   // 11-bit sums so a pipe near X=1023 cannot wrap into range.
   assign x11      = {1'b0, X};
   assign pipe_r   = x11 + 11'(PIPE_W);
   assign gap_bot  = {1'b0, Y} + 11'(GAP_H);
   assign bird_bot = {1'b0, BirdPosY} + 11'(BIRD_SIZE);

   assign on_screen = x11 < SCR_W;
   assign x_overlap = (x11 < BIRD_R) && (pipe_r > BIRD_L);
   assign y_outside = ({1'b0, BirdPosY} < {1'b0, Y}) || (bird_bot > gap_bot);

   assign hit  = on_screen && x_overlap && y_outside;
   assign pass = armed && on_screen && (pipe_r <= BIRD_L);

   // Re-arm and pass are mutually exclusive (pass implies X < BIRD_X).
   always_ff @(posedge Clk) begin
      if (Reset)               armed <= 1'b1;
      else if (x11 >= BIRD_R)  armed <= 1'b1;
      else if (pass)           armed <= 1'b0;
   end

endmodule

// File: rtl/pipe_collide_score.sv
// pipe_collide_score: round control and BCD scoring for a two-pipe game.
//   Clk, Reset            : clock, synchronous active-high reset
//   Start                 : starts a round from IDLE, acknowledges LOST
//   BirdPosY              : bird top edge
//   PipePosXA/YA, XB/YB   : pipe left edge / gap top for pipes A and B
//   Lost, Playing         : registered state flags
//   Score                 : registered two-digit BCD score, saturates at 99
// Hit/pass are evaluated combinationally; outputs follow one edge later.
module pipe_collide_score
   import pipe_collide_score_pkg::*;
#(
   parameter int unsigned BIRD_X    = DEF_BIRD_X,
   parameter int unsigned BIRD_SIZE = DEF_BIRD_SIZE,
   parameter int unsigned PIPE_W    = DEF_PIPE_W,
   parameter int unsigned GAP_H     = DEF_GAP_H,
   parameter int unsigned FLOOR_Y   = DEF_FLOOR_Y,
   parameter int unsigned SCREEN_W  = DEF_SCREEN_W
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [9:0] BirdPosY,
   input  logic [9:0] PipePosXA,
   input  logic [9:0] PipePosYA,
   input  logic [9:0] PipePosXB,
   input  logic [9:0] PipePosYB,
   output logic       Lost,
   output logic [7:0] Score,
   output logic       Playing
);

   state_t     state_q, state_d;
   logic [7:0] score_d;
   logic       hit_a, hit_b, pass_a, pass_b, ground, any_hit;

   pipe_checker #(
      .BIRD_X(BIRD_X), .BIRD_SIZE(BIRD_SIZE), .PIPE_W(PIPE_W),
      .GAP_H(GAP_H), .SCREEN_W(SCREEN_W)
   ) u_pipe_a (
      .Clk(Clk), .Reset(Reset), .X(PipePosXA), .Y(PipePosYA),
      .BirdPosY(BirdPosY), .hit(hit_a), .pass(pass_a)
   );

   pipe_checker #(
      .BIRD_X(BIRD_X), .BIRD_SIZE(BIRD_SIZE), .PIPE_W(PIPE_W),
      .GAP_H(GAP_H), .SCREEN_W(SCREEN_W)
   ) u_pipe_b (
      .Clk(Clk), .Reset(Reset), .X(PipePosXB), .Y(PipePosYB),
      .BirdPosY(BirdPosY), .hit(hit_b), .pass(pass_b)
   );

   assign ground  = {1'b0, BirdPosY} >= 11'(FLOOR_Y);
   assign any_hit = hit_a || hit_b || ground;

   // BCD +1 with saturation at 99.
   function automatic logic [7:0] bcd_inc(input logic [7:0] s);
      if (s == 8'h99)          return s;
      else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
      else                     return {s[7:4], s[3:0] + 4'd1};
   endfunction

   always_comb begin
      state_d = ST_IDLE;
      score_d = Score;
      case (state_q)
         ST_IDLE: begin
            score_d = 8'h00;
            state_d = Start ? ST_PLAY : ST_IDLE;
         end
         ST_PLAY: begin
            // A hit in the same cycle as a pass ends the round unscored.
            if (any_hit) begin
               state_d = ST_LOST;
            end else begin
               state_d = ST_PLAY;
               if (pass_a) score_d = bcd_inc(score_d);
               if (pass_b) score_d = bcd_inc(score_d);
            end
         end
         ST_LOST: begin
            if (Start) begin
               state_d = ST_IDLE;
               score_d = 8'h00;
            end else begin
               state_d = ST_LOST;
            end
         end
         default: begin
            state_d = ST_IDLE;
            score_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         Score   <= 8'h00;
         Lost    <= 1'b0;
         Playing <= 1'b0;
      end else begin
         state_q <= state_d;
         Score   <= score_d;
         Lost    <= (state_d == ST_LOST);
         Playing <= (state_d == ST_PLAY);
      end
   end

endmodule

// File: tb/tb_pipe_collide_score.sv
// Bench for pipe_collide_score: a behavioural game model pushes the expected
// outputs for each driven cycle into a queue; they are popped and compared
// after the following rising edge. Directed checks pin key scenario values.
module tb_pipe_collide_score;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1, Start = 1'b0;
   logic [9:0] BirdPosY = 10'd200;
   logic [9:0] PipePosXA = 10'd1023, PipePosYA = 10'd150;
   logic [9:0] PipePosXB = 10'd1023, PipePosYB = 10'd150;
   logic       Lost, Playing;
   logic [7:0] Score;

   pipe_collide_score dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .BirdPosY(BirdPosY),
      .PipePosXA(PipePosXA), .PipePosYA(PipePosYA),
      .PipePosXB(PipePosXB), .PipePosYB(PipePosYB),
      .Lost(Lost), .Score(Score), .Playing(Playing)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       lost;
      logic [7:0] score;
      logic       playing;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0;

   // model state: 0 idle, 1 play, 2 lost; score held as plain decimal
   int m_state = 0, m_score = 0;
   bit m_arm_a = 1, m_arm_b = 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_hit(input int x, input int y, input int by);
      return (x < 640) && (x < 220) && (x + 50 > 200) &&
             ((by < y) || (by + 20 > y + 150));
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic step(input bit rst, input bit st, input int by,
                       input int xa, input int ya, input int xb, input int yb);
      bit   hit, pa, pb;
      exp_t e;
      @(negedge Clk);
      Reset = rst; Start = st; BirdPosY = 10'(by);
      PipePosXA = 10'(xa); PipePosYA = 10'(ya);
      PipePosXB = 10'(xb); PipePosYB = 10'(yb);
      hit = m_hit(xa, ya, by) || m_hit(xb, yb, by) || (by >= 460);
      pa  = m_arm_a && (xa < 640) && (xa + 50 <= 200);
      pb  = m_arm_b && (xb < 640) && (xb + 50 <= 200);
      if (rst) begin
         m_state = 0; m_score = 0; m_arm_a = 1; m_arm_b = 1;
      end else begin
         case (m_state)
            0: begin m_score = 0; if (st) m_state = 1; end
            1: if (hit) m_state = 2;
               else begin
                  m_score = m_score + int'(pa) + int'(pb);
                  if (m_score > 99) m_score = 99;
               end
            default: if (st) begin m_state = 0; m_score = 0; end
         endcase
         if (xa >= 220) m_arm_a = 1; else if (pa) m_arm_a = 0;
         if (xb >= 220) m_arm_b = 1; else if (pb) m_arm_b = 0;
      end
      e.lost = (m_state == 2); e.score = to_bcd(m_score); e.playing = (m_state == 1);
      q.push_back(e);
      @(posedge Clk); #1;
      e = q.pop_front();
      chk("lost", int'(Lost), int'(e.lost));
      chk("score", int'(Score), int'(e.score));
      chk("playing", int'(Playing), int'(e.playing));
   endtask

   // one scored pass of pipe A: re-arm off-screen, then move fully left
   task automatic pass_a_once();
      step(0, 0, 200, 1023, 150, 1023, 150);
      step(0, 0, 200, 150, 150, 1023, 150);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_chk + 1, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      // reset with Start held: reset wins
      step(1, 1, 200, 1023, 150, 1023, 150);
      step(1, 1, 200, 1023, 150, 1023, 150);
      chk("rst_score", int'(Score), 0);
      chk("rst_lost", int'(Lost), 0);
      chk("rst_playing", int'(Playing), 0);

      // long idle-to-play run with pipes off-screen
      for (int i = 0; i < 100; i++) step(0, 1, 200, 1023, 150, 1023, 150);
      chk("run_playing", int'(Playing), 1);
      chk("run_score", int'(Score), 8'h00);

      // sweep pipe A through the bird inside the gap
      for (int x = 260; x >= 140; x -= 10) begin
         step(0, 0, 200, x, 150, 1023, 150);
         chk("sweep_lost", int'(Lost), 0);
         if (x == 150) chk("sweep_pass", int'(Score), 8'h01);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 200, 150, 150, 1023, 150);
      chk("hold_no_add", int'(Score), 8'h01);

      // to 09, then both pipes pass together
      for (int i = 0; i < 8; i++) pass_a_once();
      chk("score_09", int'(Score), 8'h09);
      step(0, 0, 200, 1023, 150, 1023, 150);
      step(0, 0, 200, 150, 150, 150, 150);
      chk("double_11", int'(Score), 8'h11);

      // to 98, double pass saturates at 99, further passes stay there
      for (int i = 0; i < 87; i++) pass_a_once();
      chk("score_98", int'(Score), 8'h98);
      step(0, 0, 200, 1023, 150, 1023, 150);
      step(0, 0, 200, 150, 150, 150, 150);
      chk("double_99", int'(Score), 8'h99);
      pass_a_once();
      chk("sat_99", int'(Score), 8'h99);

      // floor boundary
      step(0, 0, 459, 1023, 150, 1023, 150);
      chk("floor_459", int'(Lost), 0);
      step(0, 0, 460, 1023, 150, 1023, 150);
      chk("floor_460", int'(Lost), 1);
      chk("lost_frozen", int'(Score), 8'h99);
      step(0, 1, 200, 1023, 150, 1023, 150);
      chk("ack_score", int'(Score), 8'h00);
      chk("ack_lost", int'(Lost), 0);

      // pipe body hit: bird above the gap
      step(0, 1, 200, 1023, 250, 1023, 150);
      step(0, 0, 200, 210, 250, 1023, 150);
      chk("pipe_hit", int'(Lost), 1);
      step(0, 1, 200, 1023, 150, 1023, 150);
      chk("hit_ack_score", int'(Score), 8'h00);

      // pass in the same cycle as a ground hit: lost, no score
      step(0, 1, 200, 1023, 150, 1023, 150);
      pass_a_once();
      step(0, 0, 200, 1023, 150, 1023, 150);
      step(0, 0, 460, 150, 150, 1023, 150);
      chk("hit_pass_lost", int'(Lost), 1);
      chk("hit_pass_score", int'(Score), 8'h01);

      // reset in LOST with Start; pipe A held where it neither passes nor
      // re-arms, so only the reset can re-arm it
      step(0, 0, 200, 210, 150, 1023, 150);
      step(1, 1, 200, 210, 150, 1023, 150);
      chk("rst_lost_state", int'(Lost), 0);
      chk("rst_lost_score", int'(Score), 8'h00);
      step(0, 1, 200, 210, 150, 1023, 150);
      step(0, 0, 200, 150, 150, 1023, 150);
      chk("rearm_by_reset", int'(Score), 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
